dda_sequencer: RTL



---
 rtl/dda_sequencer.sv | 179 +++++++++++++++++
 1 files changed

// File: rtl/dda_sequencer.sv
// Run controller for the posit damped-oscillator DDA core: loads initial
// conditions, steps the core, and streams decimated (x, y) samples.
module dda_sequencer #(
  parameter int N       = 16,
  parameter int STEPS_W = 16,
  parameter int DECIM_W = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               abort,
  input  logic [STEPS_W-1:0] num_steps,
  input  logic [DECIM_W-1:0] decim,
  output logic               dda_rst,
  output logic               dda_en,
  input  logic [N-1:0]       x_in,
  input  logic [N-1:0]       y_in,
  output logic [N-1:0]       sample_x,
  output logic [N-1:0]       sample_y,
  output logic               sample_valid,
  input  logic               sample_ready,
  output logic [STEPS_W-1:0] step_count,
  output logic               busy,
  output logic               done
);

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_LOAD = 3'd1,
    ST_RUN  = 3'd2,
    ST_EMIT = 3'd3,
    ST_DONE = 3'd4
  } state_t;

  state_t             state_r;
  state_t             state_next_s;
  logic [STEPS_W-1:0] num_steps_r;
  logic [DECIM_W-1:0] decim_r;
  logic [STEPS_W-1:0] step_count_r;
  logic [DECIM_W-1:0] decim_cnt_r;
  logic [STEPS_W-1:0] step_count_inc_s;
  logic               decim_wrap_s;
  logic               sample_due_s;
  logic               run_complete_s;

  // Step/decimation bookkeeping for the step taken in the current RUN cycle.
  always_comb begin
    step_count_inc_s = step_count_r + {{(STEPS_W-1){1'b0}}, 1'b1};
    decim_wrap_s     = (decim_cnt_r == decim_r);
    sample_due_s     = decim_wrap_s || (step_count_inc_s == num_steps_r);
    run_complete_s   = (step_count_r == num_steps_r);
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Next-state logic; abort only matters while a run is in progress.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (start) begin
          state_next_s = ST_LOAD;
        end else begin
          state_next_s = ST_IDLE;
        end
      end
      ST_LOAD: begin
        if (abort) begin
          state_next_s = ST_IDLE;
        end else if (num_steps_r == {STEPS_W{1'b0}}) begin
          state_next_s = ST_DONE;
        end else begin
          state_next_s = ST_RUN;
        end
      end
      ST_RUN: begin
        if (abort) begin
          state_next_s = ST_IDLE;
        end else if (sample_due_s) begin
          state_next_s = ST_EMIT;
        end else begin
          state_next_s = ST_RUN;
        end
      end
      ST_EMIT: begin
        if (abort) begin
          state_next_s = ST_IDLE;
        end else if (sample_ready) begin
          state_next_s = run_complete_s ? ST_DONE : ST_RUN;
        end else begin
          state_next_s = ST_EMIT;
        end
      end
      ST_DONE: begin
        state_next_s = ST_IDLE;
      end
      default: begin
        state_next_s = ST_IDLE;
      end
    endcase
  end

  // Run parameters are captured once per start and held for the whole run.
  always_ff @(posedge clk) begin
    if (rst) begin
      num_steps_r <= {STEPS_W{1'b0}};
      decim_r     <= {DECIM_W{1'b0}};
    end else if (state_r == ST_IDLE && start) begin
      num_steps_r <= num_steps;
      decim_r     <= decim;
    end else begin
      num_steps_r <= num_steps_r;
      decim_r     <= decim_r;
    end
  end

  // The core steps on every RUN edge (even when aborting), so count it.
  always_ff @(posedge clk) begin
    if (rst) begin
      step_count_r <= {STEPS_W{1'b0}};
      decim_cnt_r  <= {DECIM_W{1'b0}};
    end else if (state_r == ST_IDLE && start) begin
      step_count_r <= {STEPS_W{1'b0}};
      decim_cnt_r  <= {DECIM_W{1'b0}};
    end else if (state_r == ST_RUN) begin
      step_count_r <= step_count_inc_s;
      decim_cnt_r  <= decim_wrap_s ? {DECIM_W{1'b0}}
                                   : decim_cnt_r + {{(DECIM_W-1){1'b0}}, 1'b1};
    end else begin
      step_count_r <= step_count_r;
      decim_cnt_r  <= decim_cnt_r;
    end
  end

  // Outputs decoded from state; dda honours reset only while enabled.
  always_comb begin
    dda_en       = 1'b0;
    dda_rst      = 1'b0;
    sample_valid = 1'b0;
    busy         = 1'b0;
    done         = 1'b0;
    case (state_r)
      ST_IDLE: begin
        busy = 1'b0;
      end
      ST_LOAD: begin
        dda_en  = 1'b1;
        dda_rst = 1'b1;
        busy    = 1'b1;
      end
      ST_RUN: begin
        dda_en = 1'b1;
        busy   = 1'b1;
      end
      ST_EMIT: begin
        sample_valid = 1'b1;
        busy         = 1'b1;
      end
      ST_DONE: begin
        done = 1'b1;
      end
      default: begin
        busy = 1'b0;
      end
    endcase
  end

  assign sample_x   = x_in;
  assign sample_y   = y_in;
  assign step_count = step_count_r;

endmodule
